wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Synthesizable, parametrised register-writeback trace buffer for the CPU pipeline. It watches NUM_CH writeback channels and records every enabled write into an on-chip FIFO, tagging each entry with channel, register address, data and an estimated PC. Entries are read out through a first-word-fall-through pop interface. It sits beside the decode/writeback stage in `toplevel` and takes its writeback and fetch-PC signals directly from there.

## Interface
- NUM_CH, 2: number of writeback channels (1..4).
- ADDR_W, 4: register address width.
- DATA_W, 16: writeback data width.
- PC_W, 16: fetch PC width.
- DEPTH, 16: FIFO entries; power of two, at least NUM_CH.
- PC_OFS_BASE, 6: PC offset for channel 0. Channel i uses `pc_fetch - (PC_OFS_BASE - i)`.
- clk  in  1  system clock.
- rst  in  1  Reset is synchronous and active-high. The block has one clock.
- capture_en  in  1  when 0, writebacks are ignored; nothing is stored or dropped.
- wb_en  in  NUM_CH  per-channel writeback strobe.
- wb_addr  in  NUM_CH*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W].
- wb_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- pc_fetch  in  PC_W  current fetch PC.
- rd_en  in  1  pop the head entry.
- rd_valid  out  1  head entry present (equal to !empty).
- rd_ch  out  CH_W  channel of head entry.
- rd_addr  out  ADDR_W  head register address.
- rd_data  out  DATA_W  head data.
- rd_pc  out  PC_W  head PC estimate.
- rd_ts  out  32  head timestamp. Present only when WB_TRACE_TIMESTAMP_EN is defined.
- count  out  $clog2(DEPTH+1)  occupancy.
- full  out  1  count == DEPTH.
- drop_cnt  out  16  saturating count of lost writebacks.

## Operation
- Each cycle, the active set is {i : wb_en[i] && capture_en}. Let k be the size of the active set.
- The active entries are pushed in ascending channel order in the same cycle.
- Free space is evaluated before any pop in that cycle: free = DEPTH - count.
- If k ≤ free, all k entries are written.
- If k > free, the lowest-numbered `free` channels are written and the rest are dropped. drop_cnt increases by (k - free) and saturates at 0xFFFF.
- PC computation is modulo 2^PC_W and wraps.
- Pop: when rd_en && rd_valid, the head advances by one. rd_en while empty is ignored and has no side effects.
- Push and pop in the same cycle are both performed: count_next = count + written - popped.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Reset values: rd_valid=0, count=0, full=0, drop_cnt=0, pointers=0. rd_* data outputs are don't-care while rd_valid=0 and must be driven to 0 after reset.
- Reset asserted mid-operation discards all entries and clears drop_cnt in the same clock edge.

## Timing
- A write accepted at edge N is visible on rd_* at N+1. This also applies when the FIFO was empty (fall-through; no extra latency).
- rd_* change only on clock edges. After a pop at edge N, the next entry is presented at N+1.
- count, full and drop_cnt are registered and reflect the state after edge N.
- No combinational path from wb_* to rd_* or to count.

## Configuration
- WB_TRACE_TIMESTAMP_EN defined:
  - A 32-bit free-running cycle counter is added. It resets to 0, increments every cycle and wraps.
  - Each entry stores the counter value at its capture cycle; all entries from one cycle share the same value.
  - The value is output on rd_ts.
- Not defined: no counter, no storage for timestamps, and no rd_ts port.

## Structure
- Package wb_trace_pkg holds:
  - CH_W = (NUM_CH>1 ? $clog2(NUM_CH) : 1) as a function;
  - the entry struct typedef {ch, addr, data, pc[, ts]};
  - the drop-counter width constant.
- Sub-module wb_trace_pack: combinational compaction of the active channels into ordered slots 0..k-1, using a prefix count of wb_en. Outputs the slot entries and k.
- Storage is a register array, giving NUM_CH write ports and one read port.

## Test plan
- Reset, then wb_en=2'b01, addr=3, data=16'hBEEF, pc_fetch=16'h0020 → next cycle rd_valid=1, rd_ch=0, rd_addr=3, rd_data=BEEF, rd_pc=16'h001A, count=1.
- wb_en=2'b11 in one cycle (ch0 R1=0x1111, ch1 R2=0x2222, pc_fetch=0x0010) → two entries in the order ch0 then ch1. rd_pc values are 0x000A and 0x000B.
- Fill to count=15, then wb_en=2'b11 → ch0 stored, ch1 dropped, full=1, drop_cnt=1. A further cycle with both channels enabled → drop_cnt=3.
- At count=DEPTH, rd_en=1 with wb_en=2'b01 in the same cycle → the pop happens and the push is dropped (free is evaluated before the pop). count=DEPTH-1, drop_cnt increments.
- pc_fetch=0x0002, ch0 write → rd_pc=0xFFFC (wrap). rd_en while empty → count stays 0.
- rst asserted with count=5, drop_cnt=2 → the next cycle has count=0, rd_valid=0, drop_cnt=0. With WB_TRACE_TIMESTAMP_EN, the first write 3 cycles after reset release has rd_ts=3.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared widths, channel-width helper and default entry layout for wb_trace_buffer
package wb_trace_pkg;
  localparam int DROP_W = 16;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_PC_W = 16;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic [ch_w(DEF_NUM_CH)-1:0] ch;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_PC_W-1:0] pc;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } entry_t;
endpackage

// File: rtl/wb_trace_pack.sv
// wb_trace_pack: compacts active writeback channels into ordered slots 0..k-1 with per-channel pc estimate
module wb_trace_pack
  import wb_trace_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int PC_W = 16,
  parameter int PC_OFS_BASE = 6,
  localparam int CH_W = ch_w(NUM_CH),
  localparam int KW = $clog2(NUM_CH + 1)
) (
  input  logic                     capture_en,
  input  logic [NUM_CH-1:0]        wb_en,
  input  logic [NUM_CH*ADDR_W-1:0] wb_addr,
  input  logic [NUM_CH*DATA_W-1:0] wb_data,
  input  logic [PC_W-1:0]          pc_fetch,
  output logic [CH_W-1:0]          slot_ch   [NUM_CH],
  output logic [ADDR_W-1:0]        slot_addr [NUM_CH],
  output logic [DATA_W-1:0]        slot_data [NUM_CH],
  output logic [PC_W-1:0]          slot_pc   [NUM_CH],
  output logic [KW-1:0]            k
);
  int n;
  always_comb begin
    n = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      slot_ch[j] = '0;
      slot_addr[j] = '0;
      slot_data[j] = '0;
      slot_pc[j] = '0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (capture_en && wb_en[i]) begin
        for (int j = 0; j < NUM_CH; j++) begin
          if (j == n) begin
            slot_ch[j] = CH_W'(i);
            slot_addr[j] = wb_addr[i*ADDR_W +: ADDR_W];
            slot_data[j] = wb_data[i*DATA_W +: DATA_W];
            slot_pc[j] = pc_fetch - PC_W'(PC_OFS_BASE - i);
          end
        end
        n = n + 1;
      end
    end
    k = KW'(n);
  end
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: writeback trace FIFO (fall-through read, drop counting); WB_TRACE_TIMESTAMP_EN adds rd_ts
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int PC_W = 16,
  parameter int DEPTH = 16,
  parameter int PC_OFS_BASE = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         capture_en,
  input  logic [NUM_CH-1:0]            wb_en,
  input  logic [NUM_CH*ADDR_W-1:0]     wb_addr,
  input  logic [NUM_CH*DATA_W-1:0]     wb_data,
  input  logic [PC_W-1:0]              pc_fetch,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [ch_w(NUM_CH)-1:0]      rd_ch,
  output logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic [PC_W-1:0]              rd_pc,
`ifdef WB_TRACE_TIMESTAMP_EN
  output logic [31:0]                  rd_ts,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic [DROP_W-1:0]            drop_cnt
);
  localparam int CH_W = ch_w(NUM_CH);
  localparam int KW = $clog2(NUM_CH + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0] pc;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } entry_t;
  entry_t mem [DEPTH];
  entry_t slot [NUM_CH];
  entry_t head;
  logic [CH_W-1:0] slot_ch [NUM_CH];
  logic [ADDR_W-1:0] slot_addr [NUM_CH];
  logic [DATA_W-1:0] slot_data [NUM_CH];
  logic [PC_W-1:0] slot_pc [NUM_CH];
  logic [KW-1:0] k, wr, lost;
  logic [CW-1:0] free, acc;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DROP_W:0] drop_sum;
  logic pop;
`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] ts;
`endif
  wb_trace_pack #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W), .PC_OFS_BASE(PC_OFS_BASE)
  ) u_pack (
    .capture_en(capture_en), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pc_fetch(pc_fetch),
    .slot_ch(slot_ch), .slot_addr(slot_addr), .slot_data(slot_data), .slot_pc(slot_pc), .k(k)
  );
  always_comb begin
    for (int j = 0; j < NUM_CH; j++) begin
`ifdef WB_TRACE_TIMESTAMP_EN
      slot[j] = {slot_ch[j], slot_addr[j], slot_data[j], slot_pc[j], ts};
`else
      slot[j] = {slot_ch[j], slot_addr[j], slot_data[j], slot_pc[j]};
`endif
    end
  end
  assign free = CW'(DEPTH) - count;
  assign acc = CW'(k) <= free ? CW'(k) : free;
  assign wr = KW'(acc);
  assign lost = k - wr;
  assign pop = rd_en && rd_valid;
  assign drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'(lost);
  assign rd_valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign head = rd_valid ? mem[rd_ptr] : '0;
  assign rd_ch = head.ch;
  assign rd_addr = head.addr;
  assign rd_data = head.data;
  assign rd_pc = head.pc;
`ifdef WB_TRACE_TIMESTAMP_EN
  assign rd_ts = head.ts;
`endif
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_CH; j++)
      if (!rst && KW'(j) < wr) mem[wr_ptr + PW'(j)] <= slot[j];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      drop_cnt <= '0;
`ifdef WB_TRACE_TIMESTAMP_EN
      ts <= '0;
`endif
    end else begin
      wr_ptr <= wr_ptr + PW'(wr);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(wr) - CW'(pop);
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
`ifdef WB_TRACE_TIMESTAMP_EN
      ts <= ts + 32'd1;
`endif
    end
  end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: randomized scoreboard bench for wb_trace_buffer against a queue-based reference
module tb_wb_trace_buffer;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, capture_en = 0, rd_en = 0;
  logic [1:0] wb_en = '0;
  logic [7:0] wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [15:0] pc_fetch = '0;
  logic rd_valid, full;
  logic [0:0] rd_ch;
  logic [3:0] rd_addr;
  logic [15:0] rd_data, rd_pc, drop_cnt;
  logic [4:0] count;
`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] rd_ts;
`endif
  typedef struct {
    int ch;
    int addr;
    int data;
    int pc;
    longint ts;
  } exp_t;
  exp_t sb[$];
  int cq[$], dq[$];
  int m_cnt = 0, m_drop = 0;
  longint m_ts = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  wb_trace_buffer dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .pc_fetch(pc_fetch), .rd_en(rd_en), .rd_valid(rd_valid), .rd_ch(rd_ch),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pc(rd_pc),
`ifdef WB_TRACE_TIMESTAMP_EN
    .rd_ts(rd_ts),
`endif
    .count(count), .full(full), .drop_cnt(drop_cnt)
  );
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock of stimulus; the reference model states what the upcoming edge must do
  task automatic step(input bit r, input bit c, input bit [1:0] e, input bit [3:0] a0, input bit [3:0] a1,
                      input bit [15:0] d0, input bit [15:0] d1, input bit [15:0] p, input bit re);
    int free, had;
    @(posedge clk);
    #1;
    rst = r; capture_en = c; wb_en = e; wb_addr = {a1, a0}; wb_data = {d1, d0}; pc_fetch = p; rd_en = re;
    if (r) begin
      sb.delete();
      m_cnt = 0; m_drop = 0; m_ts = 0;
    end else begin
      had = m_cnt;
      free = DEPTH - m_cnt;
      for (int i = 0; i < 2; i++) begin
        if (c && e[i]) begin
          if (free > 0) begin
            sb.push_back('{i, i == 0 ? a0 : a1, i == 0 ? d0 : d1, (p - (6 - i)) & 16'hFFFF, m_ts});
            free--; m_cnt++;
          end else m_drop = m_drop == 65535 ? 65535 : m_drop + 1;
        end
      end
      if (re && had > 0) m_cnt--;
      m_ts = (m_ts + 1) % 64'h1_0000_0000;
    end
    cq.push_back(m_cnt);
    dq.push_back(m_drop);
  endtask
  task automatic idle(input bit re);
    step(0, 1, 2'b00, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, re);
  endtask
  task automatic put(input bit [1:0] e, input bit [3:0] a0, input bit [3:0] a1, input bit [15:0] d0,
                     input bit [15:0] d1, input bit [15:0] p, input bit re);
    step(0, 1, e, a0, a1, d0, d1, p, re);
  endtask
  initial begin
    exp_t x;
    int ec, ed;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (cq.size() >= 2) begin
        ec = cq.pop_front();
        ed = dq.pop_front();
        chk("count", count, ec);
        chk("full", full, ec == DEPTH);
        chk("rd_valid", rd_valid, ec != 0);
        chk("drop_cnt", drop_cnt, ed);
      end
      if (!rd_valid) chk("idle_zero", {rd_ch, rd_addr, rd_data, rd_pc}, 0);
      if (rd_en && rd_valid) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          x = sb.pop_front();
          chk("rd_ch", rd_ch, x.ch);
          chk("rd_addr", rd_addr, x.addr);
          chk("rd_data", rd_data, x.data);
          chk("rd_pc", rd_pc, x.pc);
`ifdef WB_TRACE_TIMESTAMP_EN
          chk("rd_ts", rd_ts, x.ts);
`endif
        end
      end
    end
  end
  initial begin
    bit r, re;
    step(1, 0, 2'b00, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 0);
    step(1, 0, 2'b00, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 0);
    put(2'b01, 4'd3, 4'd0, 16'hBEEF, 16'h0, 16'h0020, 0);
    idle(1);
    put(2'b11, 4'd1, 4'd2, 16'h1111, 16'h2222, 16'h0010, 0);
    idle(1);
    idle(1);
    for (int i = 0; i < 15; i++) put(2'b01, 4'(i), 4'd0, 16'(i * 3 + 1), 16'h0, 16'(i), 0);
    put(2'b11, 4'hA, 4'hB, 16'hAAAA, 16'hBBBB, 16'h0100, 0);
    put(2'b11, 4'hC, 4'hD, 16'hCCCC, 16'hDDDD, 16'h0200, 0);
    put(2'b01, 4'hE, 4'h0, 16'hEEEE, 16'h0, 16'h0300, 1);
    for (int i = 0; i < 17; i++) idle(1);
    put(2'b01, 4'd7, 4'd0, 16'h5A5A, 16'h0, 16'h0002, 0);
    idle(1);
    idle(1);
    idle(1);
    step(0, 0, 2'b11, 4'd1, 4'd2, 16'h1, 16'h2, 16'h40, 0);
    for (int i = 0; i < 5; i++) put(2'b10, 4'd0, 4'(i), 16'h0, 16'(i), 16'h0050, 0);
    step(1, 0, 2'b00, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 0);
    idle(0);
    idle(0);
    idle(0);
    put(2'b01, 4'd9, 4'd0, 16'h1234, 16'h0, 16'h0400, 0);
    idle(1);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(199) == 0;
      re = n < 1500 ? $urandom_range(2) == 0 : $urandom_range(2) != 0;
      step(r, $urandom_range(9) != 0, 2'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), r ? 1'b0 : re);
    end
    for (int i = 0; i < 20; i++) idle(1);
    idle(0);
    idle(0);
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
